// File: rtl/bin32_to_bcd8.sv
// bin32_to_bcd8 - sequential binary-to-BCD converter (double dabble).
//
// Converts an unsigned IN_W-bit value to its lowest DIGITS decimal digits,
// one input bit per clock, behind a start/done handshake. Digit k of the
// result sits in TARGET_OUT[4k+3:4k].
//
// Ports:
//   cp          system clock, rising edge
//   rst_n       asynchronous active-low reset
//   start       conversion request, honoured only while idle
//   SOURCE_IN   binary value, captured on the accepted start edge
//   TARGET_OUT  packed BCD result, held until the next conversion completes
//   busy        high while a conversion is in flight
//   done        one-cycle pulse when TARGET_OUT has just been updated
//   ovf         last value had non-zero decimal digits above DIGITS
//
// State table:
//   state    | meaning
//   S_IDLE   | waiting for start
//   S_SHIFT  | one add-3/shift iteration per clock, IN_W iterations
//   S_FINISH | publish result and ovf, pulse done
module bin32_to_bcd8 #(
  parameter int IN_W   = 32,
  parameter int DIGITS = 8
) (
  input  logic                  cp,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [IN_W-1:0]       SOURCE_IN,
  output logic [4*DIGITS-1:0]   TARGET_OUT,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf
);

  // 10 digits cover the full 32-bit range (max 4294967295).
  localparam int ACC_D = 10;
  localparam int ACC_W = 4 * ACC_D;
  localparam int CNT_W = $clog2(IN_W);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SHIFT  = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_next_state;
  logic [IN_W-1:0]    r_sreg;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic [ACC_W-1:0]   w_acc_adj;
  logic [ACC_W-1:0]   w_acc_nxt;
  logic               w_cnt_tc;
  logic               w_load;
  logic               w_shift;
  logic               w_finish;

  // Iteration timer: loaded with IN_W-1, the shift taken at zero is the last.
  assign w_cnt_tc = (r_cnt == '0);

  // State register
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next_state;
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start)    w_next_state = S_SHIFT;
      S_SHIFT:  if (w_cnt_tc) w_next_state = S_FINISH;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output/control decode
  always_comb begin
    w_load   = 1'b0;
    w_shift  = 1'b0;
    w_finish = 1'b0;
    case (r_state)
      S_IDLE:   w_load   = start;
      S_SHIFT:  w_shift  = 1'b1;
      S_FINISH: w_finish = 1'b1;
      default:  ;
    endcase
  end

  // Add 3 to every digit >= 5 so the following doubling carries correctly.
  always_comb begin
    w_acc_adj = r_acc;
    for (int i = 0; i < ACC_D; i++) begin
      if (r_acc[4*i +: 4] >= 4'd5)
        w_acc_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
    end
  end

  // Accumulator takes the shift-register MSB as its new LSB.
  assign w_acc_nxt = (w_acc_adj << 1) | {{(ACC_W-1){1'b0}}, r_sreg[IN_W-1]};

  // Datapath and registered outputs
  always_ff @(posedge cp or negedge rst_n) begin
    if (!rst_n) begin
      r_sreg     <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      TARGET_OUT <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      busy <= (w_next_state != S_IDLE);
      done <= w_finish;
      if (w_load) begin
        r_sreg <= SOURCE_IN;
        r_acc  <= '0;
        r_cnt  <= CNT_W'(IN_W - 1);
      end else if (w_shift) begin
        r_sreg <= r_sreg << 1;
        r_acc  <= w_acc_nxt;
        if (!w_cnt_tc) r_cnt <= r_cnt - 1'b1;
      end
      if (w_finish) begin
        TARGET_OUT <= r_acc[4*DIGITS-1:0];
        ovf        <= |r_acc[ACC_W-1:4*DIGITS];
      end
    end
  end

endmodule

// File: tb/tb_bin32_to_bcd8.sv
module tb_bin32_to_bcd8;

  logic        cp;
  logic        rst_n;
  logic        start;
  logic [31:0] SOURCE_IN;
  logic [31:0] TARGET_OUT;
  logic        busy;
  logic        done;
  logic        ovf;

  int n_chk = 0;
  int n_bad = 0;

  bin32_to_bcd8 #(.IN_W(32), .DIGITS(8)) u_dut (
    .cp         (cp),
    .rst_n      (rst_n),
    .start      (start),
    .SOURCE_IN  (SOURCE_IN),
    .TARGET_OUT (TARGET_OUT),
    .busy       (busy),
    .done       (done),
    .ovf        (ovf)
  );

  initial cp = 1'b0;
  always #5 cp = ~cp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h", tag, obs, exp);
    end
  endtask

  // Start a conversion and watch 40 samples (one per negedge, sample k
  // follows the k-th edge after the start edge). Optionally pulse a second
  // start with a new SOURCE_IN at sample inj_at while the first is running.
  task automatic do_conv(input string tag, input logic [31:0] val,
                         input logic [31:0] exp, input logic exp_ovf,
                         input int inj_at, input logic [31:0] inj_val);
    int b_cnt;
    int d_cnt;
    int d_at;
    logic dig_ok;
    @(negedge cp);
    SOURCE_IN = val;
    start     = 1'b1;
    @(negedge cp);
    start = 1'b0;
    b_cnt = 0;
    d_cnt = 0;
    d_at  = -1;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) @(negedge cp);
      if (busy) b_cnt++;
      if (done) begin
        d_cnt++;
        if (d_at < 0) d_at = k;
      end
      if (k == inj_at) begin
        start     = 1'b1;
        SOURCE_IN = inj_val;
      end else begin
        start = 1'b0;
      end
    end
    dig_ok = 1'b1;
    for (int i = 0; i < 8; i++)
      if (TARGET_OUT[4*i +: 4] > 4'd9) dig_ok = 1'b0;
    chk({tag, " busy_cycles"}, 32'(b_cnt), 32'd33);
    chk({tag, " done_pulses"}, 32'(d_cnt), 32'd1);
    chk({tag, " done_latency"}, 32'(d_at), 32'd33);
    chk({tag, " result"}, TARGET_OUT, exp);
    chk({tag, " ovf"}, {31'd0, ovf}, {31'd0, exp_ovf});
    chk({tag, " digits_valid"}, {31'd0, dig_ok}, 32'd1);
  endtask

  initial begin
    int d_seen;
    rst_n     = 1'b0;
    start     = 1'b0;
    SOURCE_IN = 32'd0;
    repeat (3) @(negedge cp);
    rst_n = 1'b1;
    repeat (3) @(negedge cp);
    chk("reset result", TARGET_OUT, 32'h0);
    chk("reset busy", {31'd0, busy}, 32'd0);
    chk("reset done", {31'd0, done}, 32'd0);
    chk("reset ovf", {31'd0, ovf}, 32'd0);

    do_conv("c12345678", 32'h00BC614E, 32'h12345678, 1'b0, -1, 32'h0);
    do_conv("c99999999", 32'h05F5E0FF, 32'h99999999, 1'b0, -1, 32'h0);
    do_conv("c1e8", 32'h05F5E100, 32'h00000000, 1'b1, -1, 32'h0);
    do_conv("czero", 32'h00000000, 32'h00000000, 1'b0, -1, 32'h0);
    do_conv("cignore", 32'h0000000A, 32'h00000010, 1'b0, 10, 32'h00000063);
    do_conv("cmax", 32'hFFFFFFFF, 32'h94967295, 1'b1, -1, 32'h0);

    // Reset in the middle of a conversion
    @(negedge cp);
    SOURCE_IN = 32'h00BC614E;
    start     = 1'b1;
    @(negedge cp);
    start = 1'b0;
    repeat (15) @(negedge cp);
    chk("midrst busy_before", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst result", TARGET_OUT, 32'h0);
    chk("midrst ovf", {31'd0, ovf}, 32'd0);
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst done", {31'd0, done}, 32'd0);
    d_seen = 0;
    repeat (2) begin
      @(negedge cp);
      if (done) d_seen++;
    end
    rst_n = 1'b1;
    repeat (40) begin
      @(negedge cp);
      if (done || busy) d_seen++;
    end
    chk("midrst no_done", 32'(d_seen), 32'd0);
    chk("midrst result_held", TARGET_OUT, 32'h0);

    do_conv("c123", 32'h0000007B, 32'h00000123, 1'b0, -1, 32'h0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
